// File: rtl/fb_arbiter.sv
// Framebuffer RAM arbiter: display read > clear sweep > host write.
// Optional FB_ARB_STATS_EN adds drop_count and clr_done outputs.
module fb_arbiter #(
    parameter int   WIDTH       = 640,
    parameter int   HEIGHT      = 480,
    parameter int   ADDR_W      = 19,
    parameter logic CLEAR_VALUE = 1'b0
) (
    input  logic              CLK100MHZ,
    input  logic              CPU_RESETN,
    input  logic              pix_tick,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_data,
    output logic              disp_valid,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_data,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic              ram_wdata,
`ifdef FB_ARB_STATS_EN
    output logic [15:0]       drop_count,
    output logic              clr_done,
`endif
    input  logic              ram_rdata
);

    localparam int TOTAL = WIDTH * HEIGHT;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TOTAL - 1);
    localparam logic [ADDR_W:0] TOTAL_W = (ADDR_W + 1)'(TOTAL);

    typedef enum logic {S_IDLE, S_CLEAR} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_we_q, ram_we_d;
    logic              ram_wdata_q, ram_wdata_d;
    logic              rd1_q, rd1_d;
    logic              rd2_q, rd2_d;
    logic              dvalid_q, dvalid_d;
    logic              ddata_q, ddata_d;
    logic              wr_fire;
    logic              wr_in_range;
    logic              clr_fin;

    assign clr_busy    = (state_q == S_CLEAR);
    assign wr_ready    = ~pix_tick & ~clr_busy & ~clr_req;
    assign wr_fire     = wr_valid & wr_ready;
    assign wr_in_range = ({1'b0, wr_addr} < TOTAL_W);

    assign ram_addr   = ram_addr_q;
    assign ram_we     = ram_we_q;
    assign ram_wdata  = ram_wdata_q;
    assign disp_data  = ddata_q;
    assign disp_valid = dvalid_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        rd1_d       = 1'b0;
        clr_fin     = 1'b0;

        if (state_q == S_IDLE && clr_req) begin
            state_d = S_CLEAR;
            cnt_d   = '0;
        end

        if (pix_tick) begin
            ram_addr_d = disp_addr;
            rd1_d      = 1'b1;
        end else if (clr_busy) begin
            ram_addr_d  = cnt_q;
            ram_we_d    = 1'b1;
            ram_wdata_d = CLEAR_VALUE;
            if (cnt_q == LAST) begin
                state_d = S_IDLE;
                clr_fin = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (wr_fire && wr_in_range) begin
            ram_addr_d  = wr_addr;
            ram_we_d    = 1'b1;
            ram_wdata_d = wr_data;
        end

        // read data lands one cycle after the address; capture it then
        rd2_d    = rd1_q;
        dvalid_d = rd2_q;
        ddata_d  = rd2_q ? ram_rdata : ddata_q;
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= 1'b0;
            rd1_q       <= 1'b0;
            rd2_q       <= 1'b0;
            dvalid_q    <= 1'b0;
            ddata_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            rd1_q       <= rd1_d;
            rd2_q       <= rd2_d;
            dvalid_q    <= dvalid_d;
            ddata_q     <= ddata_d;
        end
    end

`ifdef FB_ARB_STATS_EN
    logic [15:0] drop_q, drop_d;
    logic        done_q, done_d;

    always_comb begin
        drop_d = drop_q;
        done_d = clr_fin;
        if (wr_fire && !wr_in_range && drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            drop_q <= '0;
            done_q <= 1'b0;
        end else begin
            drop_q <= drop_d;
            done_q <= done_d;
        end
    end

    assign drop_count = drop_q;
    assign clr_done   = done_q;
`endif

endmodule
